// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Writer side of the instruction memory. Receives a framed
//                byte stream (word count N, then 4*N little-endian data
//                bytes), writes 32-bit words into the instruction RAM and
//                holds the CPU until a complete image is in place.
//  Option      : IMEM_LOADER_CHECKSUM_EN adds a one-byte XOR trailer check.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // Largest legal word count: the full RAM depth.
    localparam logic [31:0] C_DEPTH = 32'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_FIN  = 3'd3,
        S_CSUM = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2,
        S_FIN  = 2'd3
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W:0]   word_q, word_d;
    logic [23:0]       shift_q, shift_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              w_xfer;
    logic [ADDR_W:0]   w_word_inc;

    // The loader is ready whenever it expects a stream byte.
    always_comb begin
        byte_ready = (state_q == S_LEN) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (state_q == S_CSUM)
`endif
                     ;
    end

    assign w_xfer     = byte_valid && byte_ready;
    assign w_word_inc = word_q + 1'b1;

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign cpu_hold = hold_q;
    assign err      = err_q;
    assign done     = (state_q == S_FIN);

    // Next-state logic: frame parsing, word assembly and hold control.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        lane_d  = lane_q;
        word_d  = word_q;
        shift_d = shift_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN;
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                    lane_d  = 2'd0;
                    word_d  = '0;
                end
            end
            S_LEN: begin
                if (w_xfer) begin
                    n_d = byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = byte_data;
`endif
                    if (32'(byte_data) > C_DEPTH) begin
                        // Image cannot fit: abort with the CPU still held.
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (byte_data == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_FIN;
                        hold_d  = 1'b0;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    lane_d = lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    case (lane_q)
                        2'd0: shift_d[7:0]   = byte_data;
                        2'd1: shift_d[15:8]  = byte_data;
                        2'd2: shift_d[23:16] = byte_data;
                        default: begin
                            // Fourth byte completes the word: write it next cycle.
                            we_d    = 1'b1;
                            waddr_d = word_q[ADDR_W-1:0];
                            wdata_d = {byte_data, shift_q};
                            word_d  = w_word_inc;
                            if (32'(w_word_inc) == 32'(n_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_d = S_CSUM;
`else
                                state_d = S_FIN;
                                hold_d  = 1'b0;
`endif
                            end
                        end
                    endcase
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_xfer) begin
                    if (byte_data == csum_q) begin
                        state_d = S_FIN;
                        hold_d  = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset discards any partial frame and holds the CPU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            n_q     <= 8'd0;
            lane_q  <= 2'd0;
            word_q  <= '0;
            shift_q <= 24'd0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'd0;
            hold_q  <= 1'b1;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            shift_q <= shift_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Frames are built as
//                byte queues; the expected writes, done and err are derived
//                directly from the frame contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Observed write / done activity.
    int          obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = -1;

    // Expected writes.
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_cyc[$];

    logic [7:0]  frame[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            obs_addr.push_back(int'(waddr));
            obs_data.push_back(wdata);
            obs_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_obs();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    // Present one byte until accepted; xc is the cycle in which it transfers.
    task automatic send_byte(input logic [7:0] b, output bit ok, output int xc);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = (byte_ready === 1'b1);
        xc = cyc;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic append_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'd0;
        foreach (frame[i]) x ^= frame[i];
        frame.push_back(x);
`endif
    endtask

    task automatic make_frame(input int n);
        logic [7:0] nb = n[7:0];
        frame.delete();
        frame.push_back(nb);
        for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
        append_csum();
    endtask

    // Load the global frame and check writes / done / err / hold afterwards.
    // gapmode: 0 = back-to-back, 1 = valid toggling, 2 = random gaps.
    task automatic run_frame(input string name, input int gapmode);
        int  n, nacc, xc, last_xc;
        bit  ok, success;
        n = int'(frame[0]);
        clear_obs();
        pulse_start();
        checks++;
        if (cpu_hold !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s start: cpu_hold=%b err=%b, required cpu_hold=1 err=0", name, cpu_hold, err);
        end
        if (n > DEPTH) nacc = 1;
        else begin
            nacc = 1 + 4 * n;
`ifdef IMEM_LOADER_CHECKSUM_EN
            nacc++;
`endif
        end
        success = (n <= DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (success) begin
            logic [7:0] x = 8'd0;
            for (int i = 0; i <= 4 * n; i++) x ^= frame[i];
            success = (x == frame[4 * n + 1]);
        end
`endif
        last_xc = 0;
        for (int j = 0; j < nacc; j++) begin
            if (gapmode == 1 && j > 0) @(negedge clk);
            if (gapmode == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(frame[j], ok, xc);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL %s byte %0d: not accepted within budget, required acceptance", name, j);
                break;
            end
            last_xc = xc;
            if (j >= 1 && j <= 4 * n && (j % 4) == 0) begin
                exp_addr.push_back(j / 4 - 1);
                exp_data.push_back({frame[j], frame[j-1], frame[j-2], frame[j-3]});
                exp_cyc.push_back(xc + 1);
            end
        end
        repeat (4) @(negedge clk);

        checks++;
        if (obs_addr.size() !== exp_addr.size()) begin
            errors++;
            $display("FAIL %s write count: got %0d, required %0d", name, obs_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[k]) begin
                checks++;
                if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k] || obs_cyc[k] !== exp_cyc[k]) begin
                    errors++;
                    $display("FAIL %s write %0d: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             name, k, obs_addr[k], obs_data[k], obs_cyc[k], exp_addr[k], exp_data[k], exp_cyc[k]);
                end
            end
        end
        checks++;
        if (done_cnt !== (success ? 1 : 0)) begin
            errors++;
            $display("FAIL %s done count: got %0d, required %0d", name, done_cnt, success ? 1 : 0);
        end
        if (success) begin
            checks++;
            if (done_cyc !== last_xc + 1) begin
                errors++;
                $display("FAIL %s done timing: got cycle %0d, required %0d", name, done_cyc, last_xc + 1);
            end
        end
        checks++;
        if (err !== !success || cpu_hold !== !success || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s end state: err=%b cpu_hold=%b byte_ready=%b, required err=%b cpu_hold=%b byte_ready=0",
                     name, err, cpu_hold, byte_ready, !success, !success);
        end
    endtask

    task automatic test_reset();
        bit rdy_seen = 1'b0;
        clear_obs();
        repeat (3) @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b1 || byte_ready !== 1'b0 || we !== 1'b0 || done !== 1'b0 || err !== 1'b0
            || waddr !== '0 || wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: hold=%b rdy=%b we=%b done=%b err=%b waddr=%0d wdata=%h, required 1 0 0 0 0 0 0",
                     cpu_hold, byte_ready, we, done, err, waddr, wdata);
        end
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            if (byte_ready !== 1'b0) rdy_seen = 1'b1;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rdy_seen || obs_addr.size() != 0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL idle_ignore: ready_seen=%b writes=%0d hold=%b, required 0 0 1", rdy_seen, obs_addr.size(), cpu_hold);
        end
    endtask

    task automatic set_basic_frame();
        frame = {8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        append_csum();
    endtask

    task automatic test_basic();
        set_basic_frame();
        run_frame("basic", 0);
        checks++;
        if (obs_data.size() != 2 || obs_data[0] !== 32'h12345678 || obs_data[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_words: got %0d writes, required 12345678 then deadbeef", obs_data.size());
        end
    endtask

    task automatic test_toggle();
        set_basic_frame();
        run_frame("toggle", 1);
    endtask

    task automatic test_overflow();
        frame = {8'h41};
        run_frame("overflow_41", 0);
        make_frame(64);
        run_frame("full_depth", 2);
        make_frame(65 + int'($urandom_range(0, 190)));
        run_frame("overflow_rand", 0);
        make_frame(0);
        run_frame("zero_len", 0);
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int xc;
        clear_obs();
        pulse_start();
        send_byte(8'h01, ok, xc);
        send_byte(8'h11, ok, xc);
        send_byte(8'h22, ok, xc);
        reset = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0 || cpu_hold !== 1'b1 || byte_ready !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values: we=%b hold=%b rdy=%b err=%b, required 0 1 0 0", we, cpu_hold, byte_ready, err);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_addr.size() != 0) begin
            errors++;
            $display("FAIL midreset_partial: got %0d writes, required 0", obs_addr.size());
        end
        frame = {8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        append_csum();
        run_frame("after_reset", 0);
        checks++;
        if (obs_data.size() != 1 || obs_addr[0] !== 0 || obs_data[0] !== 32'hDDCCBBAA) begin
            errors++;
            $display("FAIL after_reset_word: got %0d writes, required one write ddccbbaa at 0", obs_data.size());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            make_frame(int'($urandom_range(1, 9)));
            run_frame("random", 2);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        frame = {8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_frame("csum_good", 0);
        frame = {8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        run_frame("csum_bad", 0);
        frame = {8'h00, 8'h01};
        run_frame("csum_zero_bad", 0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_overflow();
        test_reset_midframe();
        test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: takes a framed byte stream (host/debug link) and writes 32-bit instruction words into the instruction RAM that the fetch stage reads by word address.
- Holds the CPU (drives PC write-enable low and keeps the pipeline in reset) until a complete program image has been written.
- Sits beside the fetch stage. Its write port feeds the instruction RAM's write side. cpu_hold is inverted into the PC write enable.

Parameters:
- ADDR_W, 6, word-address width of the instruction RAM (depth 2^ADDR_W = 64 words; the fetch stage indexes it with PC[7:2]).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader can accept a byte. A byte transfers on a cycle with byte_valid && byte_ready.
- we  output  1  instruction RAM write strobe, one cycle per word.
- waddr  output  ADDR_W  word address for the write.
- wdata  output  32  instruction word.
- cpu_hold  output  1  high means the CPU is stalled/held in reset.
- done  output  1  one-cycle pulse when an image completes successfully.
- err  output  1  sticky error flag; cleared by the next accepted start or by reset.

Behaviour:
- Reset (asynchronous, while reset=0) forces:
  - state=IDLE
  - we=0, waddr=0, wdata=0
  - byte_ready=0, done=0, err=0
  - cpu_hold=1
  - byte-lane counter=0, word counter=0
- Frame format:
  - byte 0 = N, the word count (8-bit unsigned).
  - Then 4*N data bytes, little-endian per word: the first byte goes to wdata[7:0] and the fourth to wdata[31:24].
- States: IDLE, LEN, DATA, FIN.
- IDLE:
  - byte_ready=0.
  - start=1 moves to LEN, sets cpu_hold=1, clears err, and zeroes the word and lane counters.
  - Bytes presented while in IDLE are ignored.
- LEN:
  - byte_ready=1.
  - On the transfer, latch N.
  - N=0 goes straight to FIN.
  - N > 2^ADDR_W sets err=1 and returns to IDLE. cpu_hold stays 1 and no write occurs.
  - Otherwise go to DATA.
- DATA:
  - byte_ready=1.
  - Each transfer shifts the byte into its lane and increments the lane counter (2-bit, wraps 3 to 0).
  - On the transfer of lane 3, in the next cycle: we=1, waddr=word counter, and wdata=the assembled word. Registered outputs give a latency of 1 cycle from the 4th byte to we.
  - The word counter then increments.
  - When the word counter reaches N, go to FIN. byte_ready drops in the same cycle that we asserts.
  - Cycles with byte_valid=0 hold all state; there is no timeout.
- FIN:
  - done=1 for exactly one cycle, cpu_hold=0, then IDLE.
  - cpu_hold stays 0 until the next accepted start.
- start is ignored outside IDLE.
- A reload while the CPU is running is allowed: an accepted start reasserts cpu_hold in the next cycle.
- Reset in mid-frame discards any partial word. No we is issued, and the next load starts at waddr=0.
- we is never asserted for an address >= N, and never more than once per word.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data byte, the loader enters state CSUM (byte_ready=1) and accepts one trailer byte.
  - The trailer must equal the XOR of N and all data bytes.
  - Match: go to FIN as normal.
  - Mismatch: err=1, done stays 0, cpu_hold stays 1, return to IDLE. Words already written remain in RAM.
  - With N=0 the trailer must equal 0x00.
- When not defined:
  - No CSUM state and no trailer byte; DATA (or LEN with N=0) goes directly to FIN.

Test Plan:
- Reset release -> cpu_hold=1, byte_ready=0, we=0, done=0, err=0. Stream bytes presented without start are ignored (no we).
- start, then bytes 02, 78 56 34 12, EF BE AD DE with byte_valid held high ->
  - we at waddr 0 with wdata 0x12345678, and at waddr 1 with 0xDEADBEEF, each one cycle after its 4th byte.
  - Then done pulses for one cycle and cpu_hold=0.
- Same image with byte_valid toggling 1/0 every cycle -> identical writes and values, no duplicate accepts, done once.
- start, N=0x41 with ADDR_W=6 -> err=1, state returns to IDLE, no we, cpu_hold=1. A following valid start clears err.
- start, N=01, bytes 11 22, then reset pulsed low, then a new load of N=01, AA BB CC DD -> single write at waddr 0 of 0xDDCCBBAA, with no write of the partial word.
- With IMEM_LOADER_CHECKSUM_EN: N=01, 01 02 03 04, trailer 0x05 -> done. The same frame with trailer 0x00 -> err=1, no done, cpu_hold=1.
